bram_march_tester: RTL and testbench

Self-checking initiator for a single `bram_bank` port, used in the power-test accelerator to exercise block RAM under load. On a start pulse it drives a full ascending write pass with an address-derived pattern, then a full ascending read pass, and compares every returned word against the expected value while honouring the bank's one-cycle read latency. It reports completion, pass/fail, a saturating error count and the first failing address.

---
 rtl/bram_march_tester.sv | 217 +++++++++++++++++++++
 tb/tb_bram_march_tester.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/bram_march_tester.sv
// bram_march_tester: self-checking march initiator for one block-RAM port.
// It runs an ascending write pass with pattern seed^addr, then an ascending
// read pass. Each returned word is compared one cycle after its read command.
// The tester reports done, pass, a saturating error count and the first
// failing address.
// Optional feature macro: BRAM_TESTER_INV_PASS_EN. When defined, a second
// write/read pair follows the first, using the inverted pattern.
module bram_march_tester #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 11,
    parameter int DEPTH      = 2048
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] seed,
    output logic                  bram_en,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_din,
    input  logic [DATA_WIDTH-1:0] bram_dout,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH:0]   err_count,
    output logic                  first_err_valid,
    output logic [ADDR_WIDTH-1:0] first_err_addr
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WRITE = 3'd1;
    localparam logic [2:0] ST_READ  = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   ERR_ZERO  = {(ADDR_WIDTH+1){1'b0}};
    localparam logic [ADDR_WIDTH:0]   ERR_ONE   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0]   ERR_MAX   = {(ADDR_WIDTH+1){1'b1}};

    // Address-derived test word: seed XOR address, address truncated or zero-extended.
    function automatic logic [DATA_WIDTH-1:0] pattern_f(
        input logic [DATA_WIDTH-1:0] s,
        input logic [ADDR_WIDTH-1:0] a
    );
        return s ^ DATA_WIDTH'(a);
    endfunction

    logic [2:0]            state_r;
    logic                  en_r;
    logic                  we_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [DATA_WIDTH-1:0] din_r;
    logic [DATA_WIDTH-1:0] seed_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  pass_r;
    logic [ADDR_WIDTH:0]   err_cnt_r;
    logic                  fev_r;
    logic [ADDR_WIDTH-1:0] fea_r;
    logic                  chk_v_r;
    logic [DATA_WIDTH-1:0] chk_exp_r;
    logic [ADDR_WIDTH-1:0] chk_addr_r;

    logic [ADDR_WIDTH-1:0] addr_next_s;
    logic [DATA_WIDTH-1:0] inv_mask_s;
    logic                  mismatch_s;
    logic [ADDR_WIDTH:0]   err_next_s;

`ifdef BRAM_TESTER_INV_PASS_EN
    logic inv_r;
    assign inv_mask_s = {DATA_WIDTH{inv_r}};
`else
    assign inv_mask_s = {DATA_WIDTH{1'b0}};
`endif

    assign addr_next_s = addr_r + ADDR_ONE;

    assign bram_en         = en_r;
    assign bram_we         = we_r;
    assign bram_addr       = addr_r;
    assign bram_din        = din_r;
    assign busy            = busy_r;
    assign done            = done_r;
    assign pass            = pass_r;
    assign err_count       = err_cnt_r;
    assign first_err_valid = fev_r;
    assign first_err_addr  = fea_r;

    // Compare the word returned for last cycle's read and form the saturating next count.
    always_comb begin
        mismatch_s = chk_v_r && (bram_dout != chk_exp_r);
        err_next_s = err_cnt_r;
        if (mismatch_s && (err_cnt_r != ERR_MAX)) begin
            err_next_s = err_cnt_r + ERR_ONE;
        end else begin
            err_next_s = err_cnt_r;
        end
    end

    // Sequencer: drives the bank bus, the compare pipeline and the result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            en_r       <= 1'b0;
            we_r       <= 1'b0;
            addr_r     <= ADDR_ZERO;
            din_r      <= {DATA_WIDTH{1'b0}};
            seed_r     <= {DATA_WIDTH{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            pass_r     <= 1'b0;
            err_cnt_r  <= ERR_ZERO;
            fev_r      <= 1'b0;
            fea_r      <= ADDR_ZERO;
            chk_v_r    <= 1'b0;
            chk_exp_r  <= {DATA_WIDTH{1'b0}};
            chk_addr_r <= ADDR_ZERO;
`ifdef BRAM_TESTER_INV_PASS_EN
            inv_r      <= 1'b0;
`endif
        end else begin
            done_r  <= 1'b0;
            chk_v_r <= 1'b0;
            if ((state_r != ST_IDLE) && abort) begin
                // Abort drops the bus at once; results gathered so far are frozen.
                state_r <= ST_IDLE;
                en_r    <= 1'b0;
                we_r    <= 1'b0;
                busy_r  <= 1'b0;
            end else begin
                if (mismatch_s) begin
                    err_cnt_r <= err_next_s;
                    if (!fev_r) begin
                        fev_r <= 1'b1;
                        fea_r <= chk_addr_r;
                    end
                end
                case (state_r)
                    ST_IDLE: begin
                        if (start) begin
                            state_r   <= ST_WRITE;
                            seed_r    <= seed;
                            en_r      <= 1'b1;
                            we_r      <= 1'b1;
                            addr_r    <= ADDR_ZERO;
                            din_r     <= pattern_f(seed, ADDR_ZERO);
                            busy_r    <= 1'b1;
                            pass_r    <= 1'b0;
                            err_cnt_r <= ERR_ZERO;
                            fev_r     <= 1'b0;
                            fea_r     <= ADDR_ZERO;
`ifdef BRAM_TESTER_INV_PASS_EN
                            inv_r     <= 1'b0;
`endif
                        end
                    end
                    ST_WRITE: begin
                        if (addr_r == LAST_ADDR) begin
                            state_r <= ST_READ;
                            we_r    <= 1'b0;
                            addr_r  <= ADDR_ZERO;
                        end else begin
                            addr_r <= addr_next_s;
                            din_r  <= pattern_f(seed_r, addr_next_s) ^ inv_mask_s;
                        end
                    end
                    ST_READ: begin
                        chk_v_r    <= 1'b1;
                        chk_exp_r  <= pattern_f(seed_r, addr_r) ^ inv_mask_s;
                        chk_addr_r <= addr_r;
                        if (addr_r == LAST_ADDR) begin
`ifdef BRAM_TESTER_INV_PASS_EN
                            if (!inv_r) begin
                                // Second pass rewrites every word with the inverted pattern.
                                state_r <= ST_WRITE;
                                inv_r   <= 1'b1;
                                we_r    <= 1'b1;
                                addr_r  <= ADDR_ZERO;
                                din_r   <= ~pattern_f(seed_r, ADDR_ZERO);
                            end else begin
                                state_r <= ST_DRAIN;
                                en_r    <= 1'b0;
                            end
`else
                            state_r <= ST_DRAIN;
                            en_r    <= 1'b0;
`endif
                        end else begin
                            addr_r <= addr_next_s;
                        end
                    end
                    ST_DRAIN: begin
                        // The last read word is compared now, so pass must use the updated count.
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                        pass_r  <= (err_next_s == ERR_ZERO);
                    end
                    ST_DONE: begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        en_r    <= 1'b0;
                        we_r    <= 1'b0;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bram_march_tester.sv
// Testbench for bram_march_tester with DEPTH=16, ADDR_WIDTH=4 and DATA_WIDTH=8.
// A behavioural bank with selectable read faults is attached to the DUT.
// Table-driven runs are followed by hand-written abort and reset sequences.
module tb_bram_march_tester;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int D  = 16;
`ifdef BRAM_TESTER_INV_PASS_EN
    localparam int PASSES = 2;
`else
    localparam int PASSES = 1;
`endif
    localparam int BUS_CYC  = 2 * D * PASSES;
    localparam int DONE_CYC = BUS_CYC + 2;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [DW-1:0] seed;
    logic          bram_en;
    logic          bram_we;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_din;
    logic [DW-1:0] bram_dout;
    logic          busy;
    logic          done;
    logic          pass;
    logic [AW:0]   err_count;
    logic          first_err_valid;
    logic [AW-1:0] first_err_addr;

    int n_cmp  = 0;
    int n_fail = 0;
    int fault_mode = 0;

    logic [DW-1:0] mem [0:D-1];

    bram_march_tester #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .seed(seed),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_din(bram_din), .bram_dout(bram_dout), .busy(busy), .done(done),
        .pass(pass), .err_count(err_count), .first_err_valid(first_err_valid),
        .first_err_addr(first_err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bank read with the selected fault: 1 flips bit 0 at addresses 5 and 9, 2 is stuck at zero.
    function automatic logic [DW-1:0] bank_read(input logic [AW-1:0] a);
        logic [DW-1:0] w;
        w = mem[a];
        if (fault_mode == 1 && (a == 4'd5 || a == 4'd9)) w[0] = ~w[0];
        if (fault_mode == 2) w = 8'h00;
        return w;
    endfunction

    // Behavioural bank: write-first storage, one-cycle read latency.
    always @(posedge clk) begin
        if (bram_en) begin
            if (bram_we) mem[bram_addr] <= bram_din;
            else         bram_dout <= bank_read(bram_addr);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] seed;
        int         fault;
        int         start_at;
        int         exp_err;
        logic       exp_fev;
        logic [3:0] exp_fea;
        logic       exp_pass;
    } vec_t;

    vec_t vecs [4];

    // One full run: start, watch the bus each cycle, then check results and busy fall.
    task automatic run_vec(input vec_t v, input string tag);
        int bus_bad;
        int done_at;
        int k;
        int a;
        logic wr;
        logic [7:0] e;
        bus_bad = 0;
        done_at = 0;
        @(negedge clk);
        seed = v.seed; fault_mode = v.fault; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_pass_clr"}, 32'(pass), 32'd0);
        for (int c = 1; c <= DONE_CYC + 5 && done_at == 0; c++) begin
            if (c > 1) @(negedge clk);
            start = (c == v.start_at) ? 1'b1 : 1'b0;
            if (c <= BUS_CYC) begin
                k  = (c - 1) / D;
                a  = (c - 1) % D;
                wr = ((k % 2) == 0);
                e  = v.seed ^ 8'(a);
                if (k >= 2) e = ~e;
                if (!bram_en || bram_we !== wr || bram_addr !== 4'(a) || (wr && bram_din !== e))
                    bus_bad++;
            end else if (bram_en) begin
                bus_bad++;
            end
            if (done === 1'b1) done_at = c;
        end
        start = 1'b0;
        check({tag, "_done_cyc"}, 32'(done_at), 32'(DONE_CYC));
        check({tag, "_bus_bad"}, 32'(bus_bad), 32'd0);
        check({tag, "_err"}, 32'(err_count), 32'(v.exp_err));
        check({tag, "_fev"}, 32'(first_err_valid), 32'(v.exp_fev));
        check({tag, "_fea"}, 32'(first_err_addr), 32'(v.exp_fea));
        check({tag, "_pass"}, 32'(pass), 32'(v.exp_pass));
        check({tag, "_busy_in_done"}, 32'(busy), 32'd1);
        @(negedge clk);
        check({tag, "_busy_fall"}, 32'(busy), 32'd0);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_pass_hold"}, 32'(pass), 32'(v.exp_pass));
    endtask

    initial begin
        int done_seen;
        vecs[0] = '{8'hA5, 0, 0, 0, 1'b0, 4'd0, 1'b1};
        vecs[3] = '{8'h3C, 0, 10, 0, 1'b0, 4'd0, 1'b1};
`ifdef BRAM_TESTER_INV_PASS_EN
        vecs[1] = '{8'hA5, 1, 0, 4, 1'b1, 4'd5, 1'b0};
        vecs[2] = '{8'h00, 2, 0, 31, 1'b1, 4'd1, 1'b0};
`else
        vecs[1] = '{8'hA5, 1, 0, 2, 1'b1, 4'd5, 1'b0};
        vecs[2] = '{8'h00, 2, 0, 15, 1'b1, 4'd1, 1'b0};
`endif
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; seed = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              32'({bram_en, bram_we, bram_addr, bram_din, busy, done, pass,
                   err_count, first_err_valid, first_err_addr}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
            repeat (2) @(negedge clk);
        end

        // Abort during read cycle 20 of a stuck-at run; one error already counted.
        @(negedge clk);
        seed = 8'h00; fault_mode = 2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        check("abort_cyc20_read", 32'({bram_en, bram_we}), 32'b10);
        check("abort_cyc20_err", 32'(err_count), 32'd1);
        abort = 1'b1; start = 1'b1;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        check("abort_idle", 32'({busy, bram_en, bram_we}), 32'd0);
        done_seen = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (done === 1'b1 || bram_en === 1'b1) done_seen++;
        end
        check("abort_no_done", 32'(done_seen), 32'd0);
        check("abort_pass", 32'(pass), 32'd0);
        check("abort_err_kept", 32'(err_count), 32'd1);
        check("abort_fe_kept", 32'({first_err_valid, first_err_addr}), 32'h11);

        // Asynchronous reset in the middle of the write pass.
        seed = 8'hA5; fault_mode = 0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_rst_writing", 32'({busy, bram_en, bram_we}), 32'b111);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_outputs",
              32'({bram_en, bram_we, bram_addr, bram_din, busy, done, pass,
                   err_count, first_err_valid, first_err_addr}), 32'd0);
        @(posedge clk);
        #1;
        check("rst_no_bus", 32'({bram_en, busy}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(vecs[0], "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
